// File: rtl/serial_logic_unit.sv
// serial_logic_unit: 32-bit bitwise AND/OR/XOR/NOR computed one byte per cycle, result registered on R with zero/busy/done flags
module serial_logic_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] R,
  output logic        zero,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, next;
  logic [1:0] cnt, op_q;
  logic [31:0] a_q, b_q, acc, full;
  logic [7:0] a_b, b_b, r_b;
  always_ff @(posedge clk) state <= rst ? IDLE : next;
  always_comb begin
    next = state == IDLE ? (start ? RUN : IDLE) :
           state == RUN  ? (cnt == 2'd3 ? DONE : RUN) :
                           (start ? RUN : IDLE);
  end
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
  end
  always_comb begin
    a_b = a_q[{cnt, 3'd0} +: 8];
    b_b = b_q[{cnt, 3'd0} +: 8];
    r_b = op_q == 2'd0 ? a_b & b_b :
          op_q == 2'd1 ? a_b | b_b :
          op_q == 2'd2 ? a_b ^ b_b : ~(a_b | b_b);
    full = acc;
    full[{cnt, 3'd0} +: 8] = r_b;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= 2'd0;
      op_q <= 2'd0;
      a_q  <= 32'h0;
      b_q  <= 32'h0;
      acc  <= 32'h0;
      R    <= 32'h0;
      zero <= 1'b1;
    end else begin
      if (start && state != RUN) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= op;
        cnt  <= 2'd0;
      end
      if (state == RUN) begin
        acc <= full;
        cnt <= cnt + 2'd1;
        if (cnt == 2'd3) begin
          R    <= full;
          zero <= full == 32'h0;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_logic_unit.sv
// tb_serial_logic_unit: vector table, hand sequences and random ops checked against a word-level model
module tb_serial_logic_unit;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [1:0] op = 2'd0;
  logic [31:0] A = 32'h0, B = 32'h0;
  logic [31:0] R;
  logic zero, busy, done;
  int passed = 0, total = 0;
  logic [31:0] model_r = 32'h0;
  typedef struct {logic [1:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] r;} vec_t;
  vec_t vecs[6];
  serial_logic_unit dut (.clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
                         .R(R), .zero(zero), .busy(busy), .done(done));
  always #5 clk = ~clk;
  function automatic logic [31:0] ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return o == 2'd0 ? a & b : o == 2'd1 ? a | b : o == 2'd2 ? a ^ b : ~(a | b);
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    logic [31:0] prev;
    prev = model_r;
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check({name, "_busy"}, busy, 1);
      check({name, "_early_done"}, done, 0);
      check({name, "_R_held"}, R, prev);
      start = (i == 1);
      A = $urandom;
      B = $urandom;
      op = 2'($urandom);
    end
    @(negedge clk);
    check({name, "_done"}, done, 1);
    check({name, "_busy_end"}, busy, 0);
    check({name, "_R"}, R, exp);
    check({name, "_zero"}, zero, exp == 32'h0);
    model_r = exp;
    @(negedge clk);
    check({name, "_single_done"}, done, 0);
    check({name, "_R_after"}, R, exp);
  endtask
  initial begin
    logic [9:0] dn;
    logic [31:0] rr [10];
    logic [31:0] e1, e2, ra, rb;
    logic [1:0] ro;
    int n_done;
    repeat (2) @(negedge clk);
    check("rst_R", R, 32'h0);
    check("rst_zero", zero, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    vecs[0] = '{2'd1, 32'hF0F0_0000, 32'h0F0F_00FF, 32'hFFFF_00FF};
    vecs[1] = '{2'd3, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    vecs[2] = '{2'd0, 32'h1234_5678, 32'hFFFF_0000, 32'h1234_0000};
    vecs[3] = '{2'd2, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF};
    vecs[4] = '{2'd0, 32'h00FF_00FF, 32'hFF00_FF00, 32'h0000_0000};
    vecs[5] = '{2'd3, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
    foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r);
    @(negedge clk);
    start = 1'b1; op = 2'd1; A = 32'hF0F0_0000; B = 32'h0F0F_00FF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_R", R, 32'h0);
    check("abort_zero", zero, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    rst = 1'b0;
    model_r = 32'h0;
    n_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort_no_done", n_done, 0);
    run_op("post_abort", 2'd1, 32'hF0F0_0000, 32'h0F0F_00FF, 32'hFFFF_00FF);
    e1 = ref_op(2'd2, 32'h1234_5678, 32'h0);
    e2 = ref_op(2'd0, 32'hFFFF_FFFF, 32'h0F0F_0F0F);
    @(negedge clk);
    start = 1'b1; op = 2'd2; A = 32'h1234_5678; B = 32'h0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      dn[n] = done;
      rr[n] = R;
      if (n == 0) begin op = 2'd0; A = 32'hFFFF_FFFF; B = 32'h0F0F_0F0F; end
      if (n == 5) start = 1'b0;
    end
    check("b2b_done_pattern", 32'(dn), 32'(10'b10_0001_0000));
    check("b2b_R_before", rr[3], model_r);
    check("b2b_R1", rr[4], e1);
    check("b2b_R1_held", rr[8], e1);
    check("b2b_R2", rr[9], e2);
    model_r = e2;
    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = (i % 5 == 0) ? ~ra : $urandom;
      run_op($sformatf("rnd%0d", i), ro, ra, rb, ref_op(ro, ra, rb));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/serial_logic_unit.md
SERIAL_LOGIC_UNIT -- requirements
Module: serial_logic_unit

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 32 bits and is processed 8 bits per cycle.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  request to begin an operation; sampled on a rising edge of clk.
REQ-005 op  input  2  operation select: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-006 A  input  32  first operand; sampled only on an edge where start is accepted.
REQ-007 B  input  32  second operand; sampled only on an edge where start is accepted.
REQ-008 R  output  32  registered result of the last completed operation.
REQ-009 zero  output  1  registered flag, 1 when the last completed R equals 32'h0.
REQ-010 busy  output  1  1 while an operation is in progress (state RUN).
REQ-011 done  output  1  one-cycle completion pulse (state DONE).

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN, DONE, with a 2-bit byte counter cnt.
REQ-013 IDLE: start=1 at an edge -> latch A, B, op into internal registers, cnt<=0, go to RUN; start=0 -> stay in IDLE.
REQ-014 RUN: each edge computes result byte cnt from latched operand bytes [8*cnt+7:8*cnt] per latched op, stores it into an internal accumulator, and increments cnt; byte 0 is processed first.
REQ-015 RUN: on the edge where cnt=3, the block SHALL load R with the full 32-bit accumulated result, set zero per REQ-009, and go to DONE.
REQ-016 DONE: lasts exactly one cycle; on the next edge, start=1 -> behave as REQ-013 (back-to-back accepted), else go to IDLE.
REQ-017 Latency: start accepted at edge k -> R, zero and done valid after edge k+4; the next start is accepted no earlier than edge k+5.
REQ-018 busy SHALL equal (state==RUN); done SHALL equal (state==DONE); both SHALL be decoded from registered state only.
REQ-019 start while in RUN SHALL be ignored, with no effect on operands, op or cnt.
REQ-020 Changes on A, B or op while in RUN SHALL NOT affect the result.
REQ-021 R and zero SHALL hold their values from one completion until the next completion or reset; partial results SHALL never appear on R.
REQ-022 NOR SHALL be computed as the bitwise inverse of OR, per byte; no arithmetic or carries between bytes.
REQ-023 cnt SHALL wrap only via the RUN->DONE transition; cnt is don't-care outside RUN.

Reset
REQ-024 rst=1 at an edge SHALL force state IDLE, cnt=0, R=32'h0, zero=1, busy=0, done=0, and clear the internal operand, op and accumulator registers.
REQ-025 rst SHALL take priority over start and over any state transition, including mid-RUN abort; no done pulse SHALL follow an aborted operation.
REQ-026 After rst deasserts, the first edge with start=1 SHALL be accepted normally.

Verification
REQ-027 Reset: hold rst 2 cycles -> R=0, zero=1, busy=0, done=0.
REQ-028 OR: A=32'hF0F0_0000, B=32'h0F0F_00FF, op=01, start pulse at edge k -> busy=1 for edges k+1..k+3, done=1 after edge k+4, R=32'hFFFF_00FF, zero=0.
REQ-029 NOR/zero: A=32'hFFFF_FFFF, B=0, op=11 -> R=0, zero=1; then AND with A=32'h1234_5678, B=32'hFFFF_0000 -> R=32'h1234_0000.
REQ-030 Ignore and stability: start XOR with A=32'hAAAA_AAAA, B=32'h5555_5555; during RUN pulse start and change A to 0 -> R=32'hFFFF_FFFF, exactly one done pulse.
REQ-031 Back-to-back: start held high across DONE -> second operation accepted at the DONE edge, done pulses 5 cycles apart, and R updates only at each completion.
REQ-032 Abort: assert rst at edge k+2 of an OR operation -> R=0, zero=1, no done pulse; a new start after reset completes correctly.
